muldiv_unit: RTL



---
 rtl/muldiv_unit.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// HI/LO multiply-divide unit: fixed-latency multiply with optional
// accumulate, iterative radix-2 restoring divide, MTHI/MTLO writes.
module muldiv_unit #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             start,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CMAX = (WIDTH > MUL_LAT) ? WIDTH : MUL_LAT;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_FIX} state_t;
  typedef enum logic [1:0] {ACC_SET, ACC_ADD, ACC_SUB} acc_t;

  // Decode
  logic [5:0] opcode, funct;
  logic       special, special2;
  logic       is_mthi, is_mtlo, is_mult, is_multu, is_div, is_divu;
  logic       is_madd, is_maddu, is_msub, is_msubu;
  logic       is_mulclass, is_divclass, mul_signed;
  logic       unused_instr;

  assign opcode       = instr[31:26];
  assign funct        = instr[5:0];
  assign unused_instr = ^instr[25:6];
  assign special      = (opcode == 6'h00);
  assign special2     = (opcode == 6'h1C);
  assign is_mthi      = special  && (funct == 6'd17);
  assign is_mtlo      = special  && (funct == 6'd19);
  assign is_mult      = special  && (funct == 6'd24);
  assign is_multu     = special  && (funct == 6'd25);
  assign is_div       = special  && (funct == 6'd26);
  assign is_divu      = special  && (funct == 6'd27);
  assign is_madd      = special2 && (funct == 6'd0);
  assign is_maddu     = special2 && (funct == 6'd1);
  assign is_msub      = special2 && (funct == 6'd4);
  assign is_msubu     = special2 && (funct == 6'd5);
  assign is_mulclass  = is_mult | is_multu | is_madd | is_maddu | is_msub | is_msubu;
  assign is_divclass  = is_div | is_divu;
  assign mul_signed   = is_mult | is_madd | is_msub;
  assign start        = is_mulclass | is_divclass;

  // State and datapath registers
  state_t               state, state_n;
  acc_t                 acc, acc_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [2*WIDTH-1:0]   prod, prod_n;
  logic [WIDTH-1:0]     quo, quo_n, dvs, dvs_n, rem, rem_n;
  logic                 neg_q, neg_q_n, neg_r, neg_r_n;
  logic [WIDTH-1:0]     hi_n, lo_n;
  logic                 busy_n, done_n, dz_n;

  // Operand conditioning
  logic [2*WIDTH-1:0] a_ext, b_ext, hilo;
  logic               sa, sb;
  logic [WIDTH:0]     rem_sh, diff;

  assign a_ext  = {{WIDTH{mul_signed & A[WIDTH-1]}}, A};
  assign b_ext  = {{WIDTH{mul_signed & B[WIDTH-1]}}, B};
  assign hilo   = {HI, LO};
  assign sa     = is_div & A[WIDTH-1];
  assign sb     = is_div & B[WIDTH-1];
  // quo holds the dividend; its MSB shifts into the remainder while quotient bits fill from the LSB
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  // Register all state; reset abandons any in-flight operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      acc      <= ACC_SET;
      cnt      <= '0;
      prod     <= '0;
      quo      <= '0;
      dvs      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      HI       <= '0;
      LO       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      acc      <= acc_n;
      cnt      <= cnt_n;
      prod     <= prod_n;
      quo      <= quo_n;
      dvs      <= dvs_n;
      rem      <= rem_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      HI       <= hi_n;
      LO       <= lo_n;
      busy     <= busy_n;
      done     <= done_n;
      div_zero <= dz_n;
    end
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_n = state;
    acc_n   = acc;
    cnt_n   = cnt;
    prod_n  = prod;
    quo_n   = quo;
    dvs_n   = dvs;
    rem_n   = rem;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    hi_n    = HI;
    lo_n    = LO;
    busy_n  = busy;
    done_n  = 1'b0;
    dz_n    = 1'b0;
    case (state)
      ST_IDLE: begin
        busy_n = 1'b0;
        // busy here is the divide-by-zero cycle; the instruction is stalled
        if (!busy) begin
          if (is_mthi) begin
            hi_n = A;
          end else if (is_mtlo) begin
            lo_n = A;
          end else if (is_mulclass) begin
            prod_n  = a_ext * b_ext;
            acc_n   = (is_madd | is_maddu) ? ACC_ADD :
                      (is_msub | is_msubu) ? ACC_SUB : ACC_SET;
            cnt_n   = CW'(MUL_LAT);
            busy_n  = 1'b1;
            state_n = ST_MUL;
          end else if (is_divclass) begin
            busy_n = 1'b1;
            if (B == '0) begin
              dz_n = 1'b1;
            end else begin
              quo_n   = sa ? -A : A;
              dvs_n   = sb ? -B : B;
              rem_n   = '0;
              neg_q_n = sa ^ sb;
              neg_r_n = sa;
              cnt_n   = CW'(WIDTH);
              state_n = ST_DIV;
            end
          end
        end
      end
      ST_MUL: begin
        cnt_n = cnt - CW'(1);
        if (cnt == CW'(1)) begin
          case (acc)
            ACC_ADD: {hi_n, lo_n} = hilo + prod;
            ACC_SUB: {hi_n, lo_n} = hilo - prod;
            default: {hi_n, lo_n} = prod;
          endcase
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = ST_IDLE;
        end
      end
      ST_DIV: begin
        cnt_n = cnt - CW'(1);
        if (!diff[WIDTH]) begin
          rem_n = diff[WIDTH-1:0];
          quo_n = {quo[WIDTH-2:0], 1'b1};
        end else begin
          rem_n = rem_sh[WIDTH-1:0];
          quo_n = {quo[WIDTH-2:0], 1'b0};
        end
        if (cnt == CW'(1)) state_n = ST_FIX;
      end
      ST_FIX: begin
        lo_n    = neg_q ? -quo : quo;
        hi_n    = neg_r ? -rem : rem;
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
